// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read-port bundle seen by the serial drain stage
interface fifo_uart_tx_if #(parameter int DATA_WIDTH = 8);
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    modport master (input fifo_empty, fifo_full, fifo_wr_en, fifo_data_out, output fifo_rd_en);
    modport slave (output fifo_empty, fifo_full, fifo_wr_en, fifo_data_out, input fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops FIFO words one at a time and sends each as a start/data(LSB first)/stop frame
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           frame_done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;

    state_t                state, state_n;
    logic [BW-1:0]         baud;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  bit_end, rd_ok, timing;

    assign bit_end = baud == BAUD_MAX;
    // the FIFO drops a read in any cycle where it accepts a write
    assign rd_ok   = !fifo.fifo_empty && !(fifo.fifo_wr_en && !fifo.fifo_full);
    assign timing  = state == START || state == DATA || state == STOP;

    assign fifo.fifo_rd_en = state == REQ;
    assign busy            = state != IDLE;
    assign frame_done      = state == STOP && bit_end;
    assign tx              = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = fifo.fifo_empty ? IDLE : REQ;
            REQ:     state_n = rd_ok ? LOAD : IDLE;
            LOAD:    state_n = START;
            START:   state_n = bit_end ? DATA : START;
            DATA:    state_n = bit_end && bit_idx == LAST_BIT ? STOP : DATA;
            STOP:    state_n = bit_end ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            baud    <= timing && !bit_end ? baud + 1'b1 : '0;
            bit_idx <= state != DATA ? '0 : bit_end ? bit_idx + 1'b1 : bit_idx;
            shift   <= state == LOAD ? fifo.fifo_data_out : state == DATA && bit_end ? shift >> 1 : shift;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed tests of the FIFO drain serialiser against a small FIFO model
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam int FL  = 10 * CPB;
    localparam logic [FL-1:0] DONE_AT_END = {1'b1, {(FL-1){1'b0}}};

    logic       clk = 0, rst = 1, tx, busy, frame_done;
    logic [7:0] wr_data = 0;
    int         checks = 0, failures = 0, rd_cnt = 0;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) bus();

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .fifo(bus), .tx(tx), .busy(busy), .frame_done(frame_done));

    always #5 clk = ~clk;

    // 8-deep FIFO with write-over-read priority and registered read data
    logic [7:0] mem [8];
    logic [2:0] wp = 0, rp = 0;
    logic [3:0] cnt = 0;
    logic       wa, ra;
    assign bus.fifo_empty = cnt == 0;
    assign bus.fifo_full  = cnt == 8;
    assign wa = bus.fifo_wr_en && !bus.fifo_full;
    assign ra = bus.fifo_rd_en && !bus.fifo_empty && !wa;
    always @(posedge clk) begin
        if (wa) begin mem[wp] <= wr_data; wp <= wp + 1; end
        if (ra) begin bus.fifo_data_out <= mem[rp]; rp <= rp + 1; end
        cnt <= 4'(cnt + {3'b0, wa} - {3'b0, ra});
        if (bus.fifo_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
    end

    task automatic push(input logic [7:0] b);
        bus.fifo_wr_en = 1; wr_data = b;
        @(negedge clk);
        bus.fifo_wr_en = 0;
    endtask

    // waits for a start bit, then samples one whole frame
    task automatic capture(output logic [9:0] f, output logic [FL-1:0] d, output int gap, output int bad);
        f = '0; d = '0; gap = 0; bad = 0;
        @(negedge clk);
        while (tx !== 1'b0 && gap < 200) begin gap++; @(negedge clk); end
        if (gap < 200) for (int k = 0; k < FL; k++) begin
            if (k > 0) @(negedge clk);
            if (k % CPB == 0) f[k/CPB] = tx; else if (tx !== f[k/CPB]) bad++;
            if (busy !== 1'b1) bad++;
            d[k] = frame_done;
        end
    endtask

    task automatic test_reset;
        rst = 1;
        @(negedge clk);
        push(8'hA5);
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", bus.fifo_rd_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        checks++; if (rd_cnt !== 0) begin failures++; $display("FAIL reset_no_read got=%0d exp=0", rd_cnt); end
    endtask

    task automatic test_single;
        logic [9:0] f; logic [FL-1:0] d; int gap, bad, r0;
        r0 = rd_cnt; rst = 0;
        capture(f, d, gap, bad);
        checks++; if (gap !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", gap); end
        checks++; if (f !== {1'b1, 8'hA5, 1'b0}) begin failures++; $display("FAIL single_frame got=%b exp=%b", f, {1'b1, 8'hA5, 1'b0}); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL single_bit_hold got=%0d exp=0", bad); end
        checks++; if (d !== DONE_AT_END) begin failures++; $display("FAIL single_frame_done got=%h exp=%h", d, DONE_AT_END); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy); end
        checks++; if (rd_cnt - r0 !== 1) begin failures++; $display("FAIL single_reads got=%0d exp=1", rd_cnt - r0); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] f1, f2, f3; logic [FL-1:0] d1, d2, d3; int g1, g2, g3, b1, b2, b3, r0;
        rst = 1;
        push(8'h01); push(8'hFF); push(8'h80);
        r0 = rd_cnt; rst = 0;
        capture(f1, d1, g1, b1);
        capture(f2, d2, g2, b2);
        capture(f3, d3, g3, b3);
        checks++; if (f1 !== {1'b1, 8'h01, 1'b0}) begin failures++; $display("FAIL b2b_frame1 got=%b exp=%b", f1, {1'b1, 8'h01, 1'b0}); end
        checks++; if (f2 !== {1'b1, 8'hFF, 1'b0}) begin failures++; $display("FAIL b2b_frame2 got=%b exp=%b", f2, {1'b1, 8'hFF, 1'b0}); end
        checks++; if (f3 !== {1'b1, 8'h80, 1'b0}) begin failures++; $display("FAIL b2b_frame3 got=%b exp=%b", f3, {1'b1, 8'h80, 1'b0}); end
        checks++; if (g2 !== 3 || g3 !== 3) begin failures++; $display("FAIL b2b_gap got=%0d,%0d exp=3,3", g2, g3); end
        checks++; if (b1 + b2 + b3 !== 0) begin failures++; $display("FAIL b2b_bit_hold got=%0d exp=0", b1 + b2 + b3); end
        checks++; if (d3 !== DONE_AT_END) begin failures++; $display("FAIL b2b_frame_done got=%h exp=%h", d3, DONE_AT_END); end
        @(negedge clk);
        checks++; if (rd_cnt - r0 !== 3) begin failures++; $display("FAIL b2b_reads got=%0d exp=3", rd_cnt - r0); end
        checks++; if (bus.fifo_empty !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_end got empty=%b busy=%b exp empty=1 busy=0", bus.fifo_empty, busy); end
    endtask

    task automatic test_collision;
        logic [9:0] f1, f2; logic [FL-1:0] d1, d2; int g1, g2, b1, b2, r0;
        rst = 1;
        push(8'h5A);
        r0 = rd_cnt; rst = 0;
        @(negedge clk);
        checks++; if (bus.fifo_rd_en !== 1'b1) begin failures++; $display("FAIL coll_req got=%b exp=1", bus.fifo_rd_en); end
        bus.fifo_wr_en = 1; wr_data = 8'h77;
        @(negedge clk);
        bus.fifo_wr_en = 0;
        checks++; if (busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL coll_back_idle got busy=%b rd_en=%b exp 0,0", busy, bus.fifo_rd_en); end
        capture(f1, d1, g1, b1);
        capture(f2, d2, g2, b2);
        checks++; if (g1 !== 2) begin failures++; $display("FAIL coll_retry_latency got=%0d exp=2", g1); end
        checks++; if (f1 !== {1'b1, 8'h5A, 1'b0}) begin failures++; $display("FAIL coll_head got=%b exp=%b", f1, {1'b1, 8'h5A, 1'b0}); end
        checks++; if (f2 !== {1'b1, 8'h77, 1'b0} || g2 !== 3) begin failures++; $display("FAIL coll_next got=%b gap=%0d exp=%b gap=3", f2, g2, {1'b1, 8'h77, 1'b0}); end
        @(negedge clk);
        checks++; if (rd_cnt - r0 !== 3) begin failures++; $display("FAIL coll_reads got=%0d exp=3", rd_cnt - r0); end
        checks++; if (bus.fifo_empty !== 1'b1) begin failures++; $display("FAIL coll_empty got=%b exp=1", bus.fifo_empty); end
    endtask

    task automatic test_reset_mid;
        logic [9:0] f; logic [FL-1:0] d; int gap, bad, r0, n;
        rst = 1;
        push(8'h3C); push(8'h99);
        r0 = rd_cnt; rst = 0; n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 50) begin n++; @(negedge clk); end
        checks++; if (n >= 50) begin failures++; $display("FAIL mid_start got=timeout exp=start bit"); end
        repeat (17) @(negedge clk);
        checks++; if (tx !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_bit3 got tx=%b busy=%b exp 1,1", tx, busy); end
        rst = 1;
        @(negedge clk);
        checks++; if (tx !== 1'b1 || busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL mid_abort got tx=%b busy=%b rd_en=%b exp 1,0,0", tx, busy, bus.fifo_rd_en); end
        rst = 0;
        capture(f, d, gap, bad);
        checks++; if (f !== {1'b1, 8'h99, 1'b0} || bad !== 0) begin failures++; $display("FAIL mid_next got=%b bad=%0d exp=%b bad=0", f, bad, {1'b1, 8'h99, 1'b0}); end
        @(negedge clk);
        checks++; if (rd_cnt - r0 !== 2 || bus.fifo_empty !== 1'b1) begin failures++; $display("FAIL mid_reads got=%0d empty=%b exp=2 empty=1", rd_cnt - r0, bus.fifo_empty); end
    endtask

    task automatic test_empty;
        int bad, r0;
        bad = 0; r0 = rd_cnt;
        repeat (100) begin
            @(negedge clk);
            if (bus.fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL empty_idle got=%0d exp=0", bad); end
        checks++; if (rd_cnt - r0 !== 0) begin failures++; $display("FAIL empty_reads got=%0d exp=0", rd_cnt - r0); end
    endtask

    initial begin
        bus.fifo_wr_en = 0;
        test_reset;
        test_single;
        test_back_to_back;
        test_collision;
        test_reset_mid;
        test_empty;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
